// File: rtl/nanov_load_serializer_if.sv
// Load-path bus: parallel memory read word in, serial register-file write out.
interface nanov_load_serializer_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
);
  logic             load_valid;
  logic             load_ready;
  logic [XLEN-1:0]  load_data;
  logic [2:0]       load_funct3;
  logic [1:0]       load_addr_lo;
  logic             rd_bit;
  logic             rd_wr_en;
  logic [CNT_W-1:0] rd_bit_index;
  logic             done;
  logic             err;

  // Requester side: issues loads, consumes the serial result.
  modport master (
    output load_valid, load_data, load_funct3, load_addr_lo,
    input  load_ready, rd_bit, rd_wr_en, rd_bit_index, done, err
  );

  // Serializer side.
  modport slave (
    input  load_valid, load_data, load_funct3, load_addr_lo,
    output load_ready, rd_bit, rd_wr_en, rd_bit_index, done, err
  );
endinterface

// File: rtl/nanov_load_serializer.sv
// Load serializer: aligns and extends one memory read word, then streams it
// LSB-first into the bit-serial register-file write port, one bit per clock.
module nanov_load_serializer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  nanov_load_serializer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [XLEN-1:0]  sr;
  logic [CNT_W-1:0] idx;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  ext;
  logic             legal;
  logic             accept;
  logic             last_bit;

  assign accept   = bus.load_valid && (state == S_IDLE);
  assign last_bit = (idx == CNT_W'(XLEN - 1));
  assign shifted  = bus.load_data >> {bus.load_addr_lo, 3'b000};

  // Decode funct3 into the extended value and check alignment legality.
  always_comb begin
    ext   = '0;
    legal = 1'b0;
    case (bus.load_funct3)
      3'b000: begin ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};    legal = 1'b1; end
      3'b100: begin ext = {{(XLEN-8){1'b0}}, shifted[7:0]};          legal = 1'b1; end
      3'b001: begin ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]}; legal = ~bus.load_addr_lo[0]; end
      3'b101: begin ext = {{(XLEN-16){1'b0}}, shifted[15:0]};        legal = ~bus.load_addr_lo[0]; end
      3'b010: begin ext = shifted;                                   legal = (bus.load_addr_lo == 2'b00); end
      default: begin ext = '0;                                       legal = 1'b0; end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = legal ? S_SHIFT : S_ERR;
      S_SHIFT: if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result shift register and bit index: load on legal accept, shift right
  // while streaming so the outgoing bit is always sr[0].
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr  <= '0;
      idx <= '0;
    end else if (accept && legal) begin
      sr  <= ext;
      idx <= '0;
    end else if (state == S_SHIFT) begin
      sr  <= sr >> 1;
      idx <= last_bit ? '0 : idx + 1'b1;
    end
  end

  // Outputs are pure functions of state so reset forces them immediately.
  assign bus.load_ready   = (state == S_IDLE);
  assign bus.rd_wr_en     = (state == S_SHIFT);
  assign bus.rd_bit       = (state == S_SHIFT) & sr[0];
  assign bus.rd_bit_index = (state == S_SHIFT) ? idx : '0;
  assign bus.done         = (state == S_DONE) || (state == S_ERR);
  assign bus.err          = (state == S_ERR);

endmodule

// File: tb/tb_nanov_load_serializer.sv
// Directed bench for the load serializer: table of loads plus hand-written
// reset-abort and held-valid sequences.
module tb_nanov_load_serializer;
  logic clk;
  logic rstn;
  int   n_chk;
  int   n_fail;

  nanov_load_serializer_if #(.XLEN(32), .CNT_W(5)) bus ();

  nanov_load_serializer #(.XLEN(32), .CNT_W(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [31:0] d;
    logic        exp_err;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts at the negedge of T+1; checks every shifting cycle and returns the
  // reassembled word, leaving the bench at the negedge of T+32.
  task automatic collect(input string name, output logic [31:0] got);
    got = '0;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      chk({name, "_wr_en"}, 32'(bus.rd_wr_en), 32'd1);
      chk({name, "_idx"}, 32'(bus.rd_bit_index), 32'(i));
      chk({name, "_done_low"}, 32'(bus.done), 32'd0);
      got[i] = bus.rd_bit;
    end
  endtask

  task automatic do_load(input vec_t v);
    logic [31:0] got;
    @(negedge clk);
    chk({v.name, "_ready_idle"}, 32'(bus.load_ready), 32'd1);
    bus.load_valid   = 1'b1;
    bus.load_funct3  = v.f3;
    bus.load_addr_lo = v.a;
    bus.load_data    = v.d;
    @(negedge clk);                       // T+1
    bus.load_valid = 1'b0;
    bus.load_data  = 32'h5A5A_5A5A;
    if (v.exp_err) begin
      chk({v.name, "_err"}, 32'(bus.err), 32'd1);
      chk({v.name, "_err_done"}, 32'(bus.done), 32'd1);
      chk({v.name, "_err_wr_en"}, 32'(bus.rd_wr_en), 32'd0);
      chk({v.name, "_err_ready"}, 32'(bus.load_ready), 32'd0);
      @(negedge clk);                     // T+2
      chk({v.name, "_err_ready_back"}, 32'(bus.load_ready), 32'd1);
      chk({v.name, "_err_clear"}, {30'd0, bus.err, bus.done}, 32'd0);
      chk({v.name, "_err_no_wr"}, 32'(bus.rd_wr_en), 32'd0);
    end else begin
      collect(v.name, got);
      @(negedge clk);                     // T+33
      chk({v.name, "_value"}, got, v.exp_val);
      chk({v.name, "_done"}, 32'(bus.done), 32'd1);
      chk({v.name, "_done_wr_en"}, 32'(bus.rd_wr_en), 32'd0);
      chk({v.name, "_done_ready"}, 32'(bus.load_ready), 32'd0);
      chk({v.name, "_done_noerr"}, 32'(bus.err), 32'd0);
      @(negedge clk);                     // T+34
      chk({v.name, "_ready_back"}, 32'(bus.load_ready), 32'd1);
      chk({v.name, "_done_clear"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] got;
    n_chk  = 0;
    n_fail = 0;
    bus.load_valid   = 1'b0;
    bus.load_data    = '0;
    bus.load_funct3  = '0;
    bus.load_addr_lo = '0;
    rstn = 1'b0;

    vecs.push_back('{"lw_a0",   3'b010, 2'd0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{"lb_a3",   3'b000, 2'd3, 32'h80FFFFFF, 1'b0, 32'hFFFFFF80});
    vecs.push_back('{"lbu_a3",  3'b100, 2'd3, 32'h80FFFFFF, 1'b0, 32'h00000080});
    vecs.push_back('{"lb_a1",   3'b000, 2'd1, 32'h00007F00, 1'b0, 32'h0000007F});
    vecs.push_back('{"lb_a0",   3'b000, 2'd0, 32'h123456FF, 1'b0, 32'hFFFFFFFF});
    vecs.push_back('{"lh_a2",   3'b001, 2'd2, 32'h80011234, 1'b0, 32'hFFFF8001});
    vecs.push_back('{"lhu_a2",  3'b101, 2'd2, 32'h80011234, 1'b0, 32'h00008001});
    vecs.push_back('{"lhu_a0",  3'b101, 2'd0, 32'hABCDF00F, 1'b0, 32'h0000F00F});
    vecs.push_back('{"lh_a1",   3'b001, 2'd1, 32'h80011234, 1'b1, 32'h0});
    vecs.push_back('{"lhu_a3",  3'b101, 2'd3, 32'h80011234, 1'b1, 32'h0});
    vecs.push_back('{"f3_011",  3'b011, 2'd0, 32'h11111111, 1'b1, 32'h0});
    vecs.push_back('{"f3_110",  3'b110, 2'd0, 32'h11111111, 1'b1, 32'h0});
    vecs.push_back('{"lw_a2",   3'b010, 2'd2, 32'hDEADBEEF, 1'b1, 32'h0});

    // Reset state
    #12;
    chk("rst_ready", 32'(bus.load_ready), 32'd1);
    chk("rst_outs", {27'd0, bus.rd_bit, bus.rd_wr_en, bus.done, bus.err, 1'b0}, 32'd0);
    chk("rst_idx", 32'(bus.rd_bit_index), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i]) do_load(vecs[i]);

    // Reset asserted mid-transfer at bit index 10
    @(negedge clk);
    bus.load_valid = 1'b1; bus.load_funct3 = 3'b010; bus.load_addr_lo = 2'd0;
    bus.load_data  = 32'hDEADBEEF;
    @(negedge clk);                       // T+1, idx 0
    bus.load_valid = 1'b0;
    repeat (10) @(negedge clk);           // T+11, idx 10
    chk("abort_idx10", 32'(bus.rd_bit_index), 32'd10);
    rstn = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.load_ready), 32'd1);
    chk("abort_outs", {28'd0, bus.rd_bit, bus.rd_wr_en, bus.done, bus.err}, 32'd0);
    chk("abort_idx", 32'(bus.rd_bit_index), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_held", {28'd0, bus.rd_wr_en, bus.done, bus.err, bus.rd_bit}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_abort_quiet", {29'd0, bus.rd_wr_en, bus.done, bus.err}, 32'd0);
    do_load('{"lw_after_rst", 3'b010, 2'd0, 32'h12345678, 1'b0, 32'h12345678});

    // Valid held high; inputs changing mid-transfer must be ignored
    @(negedge clk);
    bus.load_valid = 1'b1; bus.load_funct3 = 3'b010; bus.load_addr_lo = 2'd0;
    bus.load_data  = 32'hCAFEF00D;
    @(negedge clk);                       // T+1
    bus.load_data = 32'h11111111; bus.load_funct3 = 3'b000; bus.load_addr_lo = 2'd3;
    collect("held1", got);                // ends at T+32
    chk("held1_value", got, 32'hCAFEF00D);
    @(negedge clk);                       // T+33
    chk("held1_done", 32'(bus.done), 32'd1);
    chk("held1_not_ready", 32'(bus.load_ready), 32'd0);
    bus.load_data = 32'h33333333;
    @(negedge clk);                       // T+34
    chk("held2_ready", 32'(bus.load_ready), 32'd1);
    bus.load_data = 32'h0BADC0DE; bus.load_funct3 = 3'b010; bus.load_addr_lo = 2'd0;
    @(negedge clk);                       // T'+1
    bus.load_valid = 1'b0;
    bus.load_data  = 32'hFFFFFFFF;
    collect("held2", got);
    chk("held2_value", got, 32'h0BADC0DE);
    @(negedge clk);
    chk("held2_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk("held2_idle", 32'(bus.load_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
